decoder_4to16: RTL and testbench

- Registered 4-to-16 one-hot decoder with enable gating.
- Converts a 4-bit binary code into a 16-bit one-hot word. Used for select/chip-enable generation in address and control decode paths.
- Output is registered through a configurable pipeline and carries a valid flag and a one-hot integrity flag.

---
 rtl/decoder_4to16.sv | 139 +++++++++++++
 tb/tb_decoder_4to16.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_4to16.sv
// rtl/decoder_4to16.sv - registered 4-to-16 one-hot decoder with enable gating
//
// Purpose:
//   Decodes a 4-bit binary code into a 16-bit one-hot word. The decoded word
//   passes through PIPE_STAGES registers. The final stage applies the optional
//   active-low inversion. The design also registers a valid flag and a one-hot
//   integrity flag. The flag is computed from the final stage and lags out by
//   one cycle.
//
// Parameters:
//   PIPE_STAGES    - register stages from enable/in to out (1..3)
//   OUT_ACTIVE_LOW - 1: out is inverted (idle word 16'hFFFF)
//
// Optional build macro:
//   DECODER_SEEN_MASK_EN - adds the seen_clr input and the seen_mask output
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   enable     in   1  decode enable
//   in         in   4  binary select code
//   out        out 16  decoded word (registered, polarity per OUT_ACTIVE_LOW)
//   out_valid  out  1  enable delayed by PIPE_STAGES
//   onehot_err out  1  final true-polarity word has more than one bit set
//   seen_clr   in   1  (macro only) clears seen_mask; wins over accumulation
//   seen_mask  out 16  (macro only) sticky OR of valid true-polarity outputs

module decoder_4to16 #(
    parameter int PIPE_STAGES    = 1,
    parameter int OUT_ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [3:0]  in,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        onehot_err
`ifdef DECODER_SEEN_MASK_EN
    ,
    input  logic        seen_clr,
    output logic [15:0] seen_mask
`endif
);

    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
            $error("decoder_4to16: PIPE_STAGES must be in 1..3");
        end
    endgenerate

    localparam logic [15:0] POL_MASK = (OUT_ACTIVE_LOW != 0) ? 16'hFFFF : 16'h0000;

    // Stages 0..PIPE_STAGES-2 hold true-polarity words. The last stage holds the
    // output polarity, so the inversion lives only in the final register.
    logic [15:0]            stage_q [PIPE_STAGES];
    logic [15:0]            stage_d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] vld_q;
    logic [15:0]            dec_d;
    logic [15:0]            true_w;
    logic                   err_q;
    logic                   err_d;

    always_comb begin
        dec_d = 16'h0000;
        if (enable) begin
            dec_d[in] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < PIPE_STAGES; i++) begin
            stage_d[i] = 16'h0000;
        end
        stage_d[0] = dec_d;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        stage_d[PIPE_STAGES-1] = stage_d[PIPE_STAGES-1] ^ POL_MASK;
    end

    // Recover the true-polarity final word for the integrity check and the seen mask.
    assign true_w = stage_q[PIPE_STAGES-1] ^ POL_MASK;

    // w & (w-1) clears the lowest set bit. The result is non-zero only when
    // two or more bits are set. An all-zero word is legal.
    assign err_d = |(true_w & (true_w - 16'd1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                stage_q[i] <= 16'h0000;
            end
            stage_q[PIPE_STAGES-1] <= POL_MASK;
            vld_q                  <= '0;
            err_q                  <= 1'b0;
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
            vld_q[0] <= enable;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            err_q <= err_d;
        end
    end

    assign out        = stage_q[PIPE_STAGES-1];
    assign out_valid  = vld_q[PIPE_STAGES-1];
    assign onehot_err = err_q;

`ifdef DECODER_SEEN_MASK_EN
    logic [15:0] seen_q;
    logic [15:0] seen_d;

    always_comb begin
        seen_d = seen_q;
        if (seen_clr) begin
            seen_d = 16'h0000;
        end else if (vld_q[PIPE_STAGES-1]) begin
            seen_d = seen_q | true_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_q <= 16'h0000;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign seen_mask = seen_q;
`else
    // No seen-mask tracking in this build.
`endif

endmodule

// File: tb/tb_decoder_4to16.sv
// tb/tb_decoder_4to16.sv - self-checking bench for decoder_4to16

module tb_decoder_4to16;

    logic        clk = 1'b0;
    logic        rst_c;
    logic        en_c;
    logic [3:0]  in_c;
    logic        rst_b;
    logic        en_b;
    logic [3:0]  in_b;
    logic        seen_clr;

    logic [15:0] out1, out3, out2, outa;
    logic        vld1, vld3, vld2, vlda;
    logic        err1, err3, err2, erra;
`ifdef DECODER_SEEN_MASK_EN
    logic [15:0] seen1, seen3, seen2, seena;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decoder_4to16 #(.PIPE_STAGES(1), .OUT_ACTIVE_LOW(0)) u1 (
        .clk(clk), .rst_n(rst_c), .enable(en_c), .in(in_c),
        .out(out1), .out_valid(vld1), .onehot_err(err1)
`ifdef DECODER_SEEN_MASK_EN
        , .seen_clr(seen_clr), .seen_mask(seen1)
`endif
    );

    decoder_4to16 #(.PIPE_STAGES(3), .OUT_ACTIVE_LOW(0)) u3 (
        .clk(clk), .rst_n(rst_c), .enable(en_c), .in(in_c),
        .out(out3), .out_valid(vld3), .onehot_err(err3)
`ifdef DECODER_SEEN_MASK_EN
        , .seen_clr(seen_clr), .seen_mask(seen3)
`endif
    );

    decoder_4to16 #(.PIPE_STAGES(2), .OUT_ACTIVE_LOW(0)) u2 (
        .clk(clk), .rst_n(rst_b), .enable(en_b), .in(in_b),
        .out(out2), .out_valid(vld2), .onehot_err(err2)
`ifdef DECODER_SEEN_MASK_EN
        , .seen_clr(seen_clr), .seen_mask(seen2)
`endif
    );

    decoder_4to16 #(.PIPE_STAGES(1), .OUT_ACTIVE_LOW(1)) ua (
        .clk(clk), .rst_n(rst_c), .enable(en_c), .in(in_c),
        .out(outa), .out_valid(vlda), .onehot_err(erra)
`ifdef DECODER_SEEN_MASK_EN
        , .seen_clr(seen_clr), .seen_mask(seena)
`endif
    );

    typedef struct {
        logic        en;
        logic [3:0]  code;
        logic [15:0] exp_out;
        logic        exp_vld;
    } vec_t;

    vec_t vecs [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] b2b_exp [8];
        logic        b2b_vld [8];
        logic [3:0]  b2b_in  [4];

        rst_c = 1'b0; rst_b = 1'b0;
        en_c = 1'b1;  in_c = 4'd7;
        en_b = 1'b1;  in_b = 4'd7;
        seen_clr = 1'b0;

        for (int k = 0; k < 32; k++) begin
            vecs[k].code    = 4'(k >> 1);
            vecs[k].en      = k[0];
            vecs[k].exp_out = k[0] ? (16'h0001 << (k >> 1)) : 16'h0000;
            vecs[k].exp_vld = k[0];
        end

        // Reset held for three cycles with enable=1, in=7.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk16("rst_out1", out1, 16'h0000);
            chk1 ("rst_vld1", vld1, 1'b0);
            chk1 ("rst_err1", err1, 1'b0);
            chk16("rst_out3", out3, 16'h0000);
            chk1 ("rst_vld3", vld3, 1'b0);
            chk16("rst_out2", out2, 16'h0000);
            chk16("rst_outa", outa, 16'hFFFF);
            chk1 ("rst_vlda", vlda, 1'b0);
        end

        rst_c = 1'b1; rst_b = 1'b1;
        tick();
        chk16("rel1_out1", out1, 16'h0080);
        chk1 ("rel1_vld1", vld1, 1'b1);
        chk16("rel1_out3", out3, 16'h0000);
        chk16("rel1_out2", out2, 16'h0000);
        chk16("rel1_outa", outa, 16'hFF7F);
        tick();
        chk16("rel2_out3", out3, 16'h0000);
        chk16("rel2_out2", out2, 16'h0080);
        chk1 ("rel2_vld2", vld2, 1'b1);
        tick();
        chk16("rel3_out3", out3, 16'h0080);
        chk1 ("rel3_vld3", vld3, 1'b1);

        en_c = 1'b0; en_b = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk16("drain_out3", out3, 16'h0000);
        chk1 ("drain_vld3", vld3, 1'b0);

        // Exhaustive sweep on the single-stage instance.
        for (int k = 0; k < 32; k++) begin
            en_c = vecs[k].en;
            in_c = vecs[k].code;
            tick();
            chk16($sformatf("sweep_out[%0d]", k), out1, vecs[k].exp_out);
            chk1 ($sformatf("sweep_vld[%0d]", k), vld1, vecs[k].exp_vld);
            chk1 ($sformatf("sweep_err[%0d]", k), err1, 1'b0);
        end

        en_c = 1'b0;
        for (int c = 0; c < 3; c++) tick();

        // Back-to-back codes 3,9,15,0 through three stages.
        b2b_in[0] = 4'd3; b2b_in[1] = 4'd9; b2b_in[2] = 4'd15; b2b_in[3] = 4'd0;
        b2b_exp[0] = 16'h0000; b2b_vld[0] = 1'b0;
        b2b_exp[1] = 16'h0000; b2b_vld[1] = 1'b0;
        b2b_exp[2] = 16'h0008; b2b_vld[2] = 1'b1;
        b2b_exp[3] = 16'h0200; b2b_vld[3] = 1'b1;
        b2b_exp[4] = 16'h8000; b2b_vld[4] = 1'b1;
        b2b_exp[5] = 16'h0001; b2b_vld[5] = 1'b1;
        b2b_exp[6] = 16'h0000; b2b_vld[6] = 1'b0;
        b2b_exp[7] = 16'h0000; b2b_vld[7] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            en_c = (c < 4);
            in_c = (c < 4) ? b2b_in[c] : 4'd0;
            tick();
            chk16($sformatf("b2b_out[%0d]", c), out3, b2b_exp[c]);
            chk1 ($sformatf("b2b_vld[%0d]", c), vld3, b2b_vld[c]);
            chk1 ($sformatf("b2b_err[%0d]", c), err3, 1'b0);
        end

        // Active-low polarity.
        en_c = 1'b1; in_c = 4'd4;
        tick();
        chk16("al_out_sel", outa, 16'hFFEF);
        chk1 ("al_vld_sel", vlda, 1'b1);
        en_c = 1'b0;
        tick();
        chk16("al_out_idle", outa, 16'hFFFF);
        chk1 ("al_vld_idle", vlda, 1'b0);
        tick();
        chk1 ("al_err", erra, 1'b0);

        // Reset mid-stream on the two-stage instance: 16'h0400 must never appear.
        en_b = 1'b1; in_b = 4'd10;
        tick();
        rst_b = 1'b0; en_b = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk16($sformatf("mid_rst_out[%0d]", c), out2, 16'h0000);
            chk1 ($sformatf("mid_rst_vld[%0d]", c), vld2, 1'b0);
        end
        rst_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk16($sformatf("mid_post_out[%0d]", c), out2, 16'h0000);
            chk1 ($sformatf("mid_post_vld[%0d]", c), vld2, 1'b0);
        end
        en_b = 1'b1; in_b = 4'd2;
        tick();
        chk16("mid_first_wait", out2, 16'h0000);
        en_b = 1'b0;
        tick();
        chk16("mid_first_out", out2, 16'h0004);
        chk1 ("mid_first_vld", vld2, 1'b1);
        tick();
        chk1 ("mid_err", err2, 1'b0);

`ifdef DECODER_SEEN_MASK_EN
        en_c = 1'b0; seen_clr = 1'b1;
        tick();
        seen_clr = 1'b0;
        chk16("seen_cleared", seen1, 16'h0000);
        b2b_in[0] = 4'd1; b2b_in[1] = 4'd2; b2b_in[2] = 4'd1; b2b_in[3] = 4'd15;
        for (int c = 0; c < 4; c++) begin
            en_c = 1'b1; in_c = b2b_in[c];
            tick();
        end
        en_c = 1'b0;
        tick();
        chk16("seen_accum", seen1, 16'h8006);
        en_c = 1'b1; in_c = 4'd3;
        tick();
        chk16("seen_out3", out1, 16'h0008);
        en_c = 1'b0; seen_clr = 1'b1;
        tick();
        seen_clr = 1'b0;
        chk16("seen_clr_wins", seen1, 16'h0000);
        chk16("seen_al_cleared", seena, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
